// File: rtl/vector_byte_loader.sv
// Packs a UART byte stream little-endian into IWIDTH-bit words and writes one
// word per completed group of bytes to addresses 0..NINPUTS-1 of a register bank.
module vector_byte_loader #(
  parameter int IWIDTH         = 10,
  parameter int NINPUTS        = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       abort,
  input  logic [7:0]                 rx_data,
  input  logic                       rx_valid,
  output logic                       mem_we,
  output logic [$clog2(NINPUTS)-1:0] mem_addr,
  output logic [IWIDTH-1:0]          mem_wdata,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);

  localparam int BPW = (IWIDTH + 7) / 8;
  localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int WCW = $clog2(NINPUTS);
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int ASW = BPW * 8;

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_e;

  state_e            state_q, state_d;
  logic [BCW-1:0]    byte_cnt_q, byte_cnt_d;
  logic [WCW-1:0]    word_cnt_q, word_cnt_d;
  logic [TCW-1:0]    tmo_q, tmo_d;
  logic [ASW-1:0]    asm_q, asm_d;
  logic              we_q, we_d;
  logic [WCW-1:0]    addr_q, addr_d;
  logic [IWIDTH-1:0] wdata_q, wdata_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [ASW-1:0]    word_c;
  logic              last_byte, last_word, tmo_hit;

  assign last_byte = (state_q == COLLECT) && rx_valid && (byte_cnt_q == BCW'(BPW - 1));
  assign last_word = (word_cnt_q == WCW'(NINPUTS - 1));
  assign tmo_hit   = (state_q == COLLECT) && !rx_valid && (byte_cnt_q != '0) &&
                     (tmo_q == TCW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      byte_cnt_q <= '0;
      word_cnt_q <= '0;
      tmo_q      <= '0;
      asm_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      word_cnt_q <= word_cnt_d;
      tmo_q      <= tmo_d;
      asm_q      <= asm_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // DONE spans two cycles: the final write cycle, then the done pulse cycle.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start) state_d = COLLECT;
        COLLECT: if (last_byte && last_word) state_d = DONE;
        DONE:    if (done_q) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    word_c = asm_q;
    for (int b = 0; b < BPW; b++)
      if (byte_cnt_q == BCW'(b)) word_c[b*8 +: 8] = rx_data;

    byte_cnt_d = byte_cnt_q;
    word_cnt_d = word_cnt_q;
    tmo_d      = tmo_q;
    asm_d      = asm_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;

    if (abort) begin
      byte_cnt_d = '0;
      word_cnt_d = '0;
      tmo_d      = '0;
      asm_d      = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            byte_cnt_d = '0;
            word_cnt_d = '0;
            tmo_d      = '0;
            asm_d      = '0;
          end
        end
        COLLECT: begin
          if (rx_valid) begin
            tmo_d = '0;
            if (last_byte) begin
              wdata_d    = word_c[IWIDTH-1:0];
              addr_d     = word_cnt_q;
              we_d       = 1'b1;
              byte_cnt_d = '0;
              asm_d      = '0;
              word_cnt_d = last_word ? '0 : word_cnt_q + 1'b1;
            end else begin
              asm_d      = word_c;
              byte_cnt_d = byte_cnt_q + 1'b1;
            end
          end else if (byte_cnt_q != '0) begin
            if (tmo_hit) begin
              byte_cnt_d = '0;
              asm_d      = '0;
              tmo_d      = '0;
              err_d      = 1'b1;
            end else begin
              tmo_d = tmo_q + 1'b1;
            end
          end else begin
            tmo_d = '0;
          end
        end
        DONE:    done_d = !done_q;
        default: ;
      endcase
    end
  end

  always_comb begin
    busy      = (state_q != IDLE);
    done      = done_q;
    err       = err_q;
    mem_we    = we_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
  end

endmodule

// File: tb/tb_vector_byte_loader.sv
// Directed bench for vector_byte_loader: a queue of expected writes is filled as
// bytes are driven and drained by a monitor whenever mem_we is seen.
module tb_vector_byte_loader;

  localparam int IW  = 10;
  localparam int NI  = 8;
  localparam int TMO = 20;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, abort, rx_valid;
  logic [7:0]    rx_data;
  logic          mem_we, busy, done, err;
  logic [2:0]    mem_addr;
  logic [IW-1:0] mem_wdata;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int err_cnt = 0;

  typedef struct {
    logic [2:0]    addr;
    logic [IW-1:0] data;
    int            cyc;
  } wr_t;
  wr_t exp_q[$];

  vector_byte_loader #(.IWIDTH(IW), .NINPUTS(NI), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write monitor: every mem_we must match the oldest expected write, including its cycle.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (done === 1'b1) done_cnt++;
      if (err === 1'b1) err_cnt++;
      if (mem_we === 1'b1) begin
        chk("write_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          wr_t e;
          e = exp_q.pop_front();
          chk("wr_addr", 32'(mem_addr), 32'(e.addr));
          chk("wr_data", 32'(mem_wdata), 32'(e.data));
          chk("wr_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  // All tasks are entered at a negedge and return at a negedge.
  task automatic drive_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_pair(input logic [2:0] a, input logic [7:0] b0, input logic [7:0] b1);
    logic [15:0] t;
    wr_t e;
    drive_byte(b0);
    t = {b1, b0};
    e.addr = a;
    e.data = t[IW-1:0];
    e.cyc  = cyc + 1;
    exp_q.push_back(e);
    drive_byte(b1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_err;
    int errs_seen;
    logic [15:0] v;

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    #12;
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_wdata", 32'(mem_wdata), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Bytes before start are ignored.
    drive_byte(8'h55);
    drive_byte(8'h66);
    idle(3);
    chk("pre_start_busy", 32'(busy), 0);

    // Defaults, upper-bit truncation, then abort after three words.
    pulse_start();
    chk("start_busy", 32'(busy), 1);
    send_pair(3'd0, 8'h34, 8'h02);
    idle(2);
    send_pair(3'd1, 8'hFF, 8'hFF);
    idle(2);
    send_pair(3'd2, 8'h0F, 8'h01);
    idle(1);
    pulse_abort();
    idle(1);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_no_done", 32'(done_cnt), 0);

    // Full vector, bytes back to back (first byte of each word lands in the mem_we cycle).
    pulse_start();
    for (int i = 0; i < NI; i++) begin
      v = 16'(i * 3 + 1);
      send_pair(3'(i), v[7:0], v[15:8]);
    end
    chk("last_wr_done", 32'(done), 0);
    chk("last_wr_busy", 32'(busy), 1);
    idle(1);
    chk("done_pulse", 32'(done), 1);
    chk("done_busy", 32'(busy), 1);
    idle(1);
    chk("after_done", 32'(done), 0);
    chk("after_busy", 32'(busy), 0);
    chk("done_count", 32'(done_cnt), 1);

    // Timeout: a gap just under the limit is tolerated, a full gap drops the byte.
    pulse_start();
    drive_byte(8'h22);
    idle(TMO - 5);
    drive_byte(8'h00);
    v = 16'h0022;
    chk("near_tmo_err", 32'(err_cnt), 0);
    begin
      wr_t e;
      e.addr = 3'd0; e.data = v[IW-1:0]; e.cyc = cyc;
      exp_q.push_front(e);
    end
    idle(2);
    chk("near_tmo_q", 32'(exp_q.size()), 0);
    pulse_abort();
    pulse_start();
    drive_byte(8'h11);
    first_err = 0;
    errs_seen = 0;
    for (int i = 1; i <= TMO + 5; i++) begin
      @(negedge clk);
      if (err === 1'b1) begin
        errs_seen++;
        if (first_err == 0) first_err = i;
      end
    end
    chk("tmo_err_once", 32'(errs_seen), 1);
    chk("tmo_err_timing", 32'(first_err >= TMO && first_err <= TMO + 1), 1);
    chk("tmo_still_busy", 32'(busy), 1);
    send_pair(3'd0, 8'hAA, 8'h01);
    idle(1);

    // start while busy is ignored, mid-word and between words.
    send_pair(3'd1, 8'h10, 8'h02);
    pulse_start();
    drive_byte(8'h20);
    pulse_start();
    begin
      wr_t e;
      e.addr = 3'd2; e.data = 10'h320; e.cyc = cyc + 1;
      exp_q.push_back(e);
    end
    drive_byte(8'h03);
    idle(2);
    pulse_abort();

    // Asynchronous reset in the middle of a word.
    pulse_start();
    send_pair(3'd0, 8'h12, 8'h01);
    drive_byte(8'h77);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_mem_wdata", 32'(mem_wdata), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_mem_we", 32'(mem_we), 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    pulse_start();
    send_pair(3'd0, 8'h5A, 8'h03);
    idle(3);

    chk("queue_drained", 32'(exp_q.size()), 0);
    chk("total_done", 32'(done_cnt), 1);
    chk("total_err", 32'(err_cnt), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
